// File: rtl/pcm_postproc.sv
`default_nettype none
// ============================================================================
// Module   : pcm_postproc
// Purpose  : Post-processing stage behind the CIC3 PDM decimator. Takes a
//            signed IN_W-bit PCM word and applies an optional first-order DC
//            blocker, an arithmetic right shift and saturation to OUT_W bits.
//            Results are buffered in a FIFO with a valid/ready output.
//            Sticky flags report saturation and FIFO-full drops.
// Option   : PCM_POSTPROC_DCBLOCK_EN - when defined, stage 1 is the DC
//            blocker y <= x - x_prev + y - (y >>> DC_SHIFT). When undefined,
//            stage 1 is a plain register and latency is unchanged.
// Ports    : clk, rst           - clock (rising edge), async active-high reset
//            pcm_in/_valid      - input sample and its one-cycle strobe
//            out_data/_valid    - head-of-FIFO sample, FIFO non-empty
//            out_ready          - consumer accepts when out_valid & out_ready
//            flag_clear         - synchronous clear of sticky flags
//            sat_flag, ovf_flag - sticky saturation / dropped-sample flags
//            fifo_level         - current FIFO occupancy
// Revision : 1.0 - initial release
// ============================================================================
module pcm_postproc #(
    parameter int IN_W       = 24,
    parameter int OUT_W      = 16,
    parameter int OUT_SHIFT  = 3,
    parameter int DC_SHIFT   = 10,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic signed [IN_W-1:0]        pcm_in,
    input  logic                          pcm_in_valid,
    output logic signed [OUT_W-1:0]       out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    input  logic                          flag_clear,
    output logic                          sat_flag,
    output logic                          ovf_flag,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int                c_AW      = $clog2(FIFO_DEPTH);
    localparam logic [c_AW:0]     c_DEPTH   = (c_AW+1)'(FIFO_DEPTH);
    localparam logic signed [31:0] c_SAT_MAX = (32'sd1 <<< (OUT_W-1)) - 32'sd1;
    localparam logic signed [31:0] c_SAT_MIN = -(32'sd1 <<< (OUT_W-1));

    // Elaboration-time guard on the supported parameter space.
    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 64 || (FIFO_DEPTH & (FIFO_DEPTH-1)) != 0 ||
        IN_W >= 32 || OUT_W > IN_W || DC_SHIFT < 1 || DC_SHIFT > 31 ||
        OUT_SHIFT < 0 || OUT_SHIFT > 31) begin : g_param_check
        $error("pcm_postproc: unsupported parameter set");
    end

    // ------------------------------------------------------------------
    // Stage 1: DC blocker (or plain register)
    // ------------------------------------------------------------------
    logic signed [31:0] w_x;
    logic signed [31:0] r_y;
    logic               r_v1;

    assign w_x = {{(32-IN_W){pcm_in[IN_W-1]}}, pcm_in};

`ifdef PCM_POSTPROC_DCBLOCK_EN
    logic signed [31:0] r_x_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_y      <= '0;
            r_x_prev <= '0;
            r_v1     <= 1'b0;
        end else begin
            r_v1 <= pcm_in_valid;
            if (pcm_in_valid) begin
                // Differentiator plus leaky integrator, pole at 1 - 2^-DC_SHIFT.
                r_y      <= w_x - r_x_prev + r_y - (r_y >>> DC_SHIFT);
                r_x_prev <= w_x;
            end
        end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_y  <= '0;
            r_v1 <= 1'b0;
        end else begin
            r_v1 <= pcm_in_valid;
            if (pcm_in_valid) begin
                r_y <= w_x;
            end
        end
    end
`endif

    // ------------------------------------------------------------------
    // Stage 2: shift and saturate
    // ------------------------------------------------------------------
    logic signed [31:0]      w_s;
    logic                    w_hi;
    logic                    w_lo;
    logic signed [OUT_W-1:0] w_sat_val;
    logic                    w_sat_set;
    logic signed [OUT_W-1:0] r_sat;
    logic                    r_v2;

    assign w_s       = r_y >>> OUT_SHIFT;
    assign w_hi      = (w_s > c_SAT_MAX);
    assign w_lo      = (w_s < c_SAT_MIN);
    assign w_sat_val = w_hi ? c_SAT_MAX[OUT_W-1:0] :
                       w_lo ? c_SAT_MIN[OUT_W-1:0] : w_s[OUT_W-1:0];
    assign w_sat_set = r_v1 & (w_hi | w_lo);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sat <= '0;
            r_v2  <= 1'b0;
        end else begin
            r_v2 <= r_v1;
            if (r_v1) begin
                r_sat <= w_sat_val;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: output FIFO
    // ------------------------------------------------------------------
    logic signed [OUT_W-1:0] r_mem [FIFO_DEPTH];
    logic [c_AW-1:0]         r_wr_ptr;
    logic [c_AW-1:0]         r_rd_ptr;
    logic [c_AW:0]           r_count;
    logic                    w_pop;
    logic                    w_full;
    logic                    w_wr;
    logic                    w_drop;

    assign w_pop  = out_valid & out_ready;
    assign w_full = (r_count == c_DEPTH);
    // A simultaneous pop frees the slot, so a full FIFO still accepts the push.
    assign w_wr   = r_v2 & (~w_full | w_pop);
    assign w_drop = r_v2 & w_full & ~w_pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_mem[r_wr_ptr] <= r_sat;
                r_wr_ptr        <= r_wr_ptr + c_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + (c_AW+1)'(1);
                2'b01:   r_count <= r_count - (c_AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Sticky flags: a set event on the clearing edge wins.
    // ------------------------------------------------------------------
    logic r_sat_flag;
    logic r_ovf_flag;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sat_flag <= 1'b0;
            r_ovf_flag <= 1'b0;
        end else begin
            r_sat_flag <= (r_sat_flag & ~flag_clear) | w_sat_set;
            r_ovf_flag <= (r_ovf_flag & ~flag_clear) | w_drop;
        end
    end

    assign out_data   = r_mem[r_rd_ptr];
    assign out_valid  = (r_count != '0);
    assign fifo_level = r_count;
    assign sat_flag   = r_sat_flag;
    assign ovf_flag   = r_ovf_flag;

endmodule
`default_nettype wire

// File: tb/tb_pcm_postproc.sv
`default_nettype none
// ============================================================================
// Module   : tb_pcm_postproc
// Purpose  : Self-checking bench for pcm_postproc. Stimulus pushes the
//            hand-computed expected output for every accepted sample into a
//            queue; a monitor pops and compares on every output handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pcm_postproc;

    localparam int IN_W  = 24;
    localparam int OUT_W = 16;

    logic                     clk;
    logic                     rst;
    logic signed [IN_W-1:0]   pcm_in;
    logic                     pcm_in_valid;
    logic signed [OUT_W-1:0]  out_data;
    logic                     out_valid;
    logic                     out_ready;
    logic                     flag_clear;
    logic                     sat_flag;
    logic                     ovf_flag;
    logic [3:0]               fifo_level;

    int total = 0;
    int bad   = 0;
    int exp_q[$];

    pcm_postproc #(
        .IN_W(IN_W), .OUT_W(OUT_W), .OUT_SHIFT(3), .DC_SHIFT(10), .FIFO_DEPTH(8)
    ) dut (
        .clk(clk), .rst(rst), .pcm_in(pcm_in), .pcm_in_valid(pcm_in_valid),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .flag_clear(flag_clear), .sat_flag(sat_flag), .ovf_flag(ovf_flag),
        .fifo_level(fifo_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: the handshake is evaluated mid-cycle, before the edge that pops.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_output: got %0d expected none", out_data);
            end else begin
                chk("out_data", int'(out_data), exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input int val, input bit accepted, input int exp);
        pcm_in       = val[IN_W-1:0];
        pcm_in_valid = 1'b1;
        if (accepted) exp_q.push_back(exp);
        tick();
        pcm_in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        exp_q.delete();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic drain();
        int n;
        out_ready = 1'b1;
        n = 0;
        while (out_valid && n < 50) begin
            tick();
            n++;
        end
        out_ready = 1'b0;
        chk("drain_done", int'(out_valid), 0);
        chk("queue_empty", exp_q.size(), 0);
    endtask

    task automatic clear_flags();
        flag_clear = 1'b1;
        tick();
        flag_clear = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int exp2;
        rst          = 1'b1;
        pcm_in       = '0;
        pcm_in_valid = 1'b0;
        out_ready    = 1'b0;
        flag_clear   = 1'b0;
        tick();
        tick();
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_level", int'(fifo_level), 0);
        chk("rst_sat", int'(sat_flag), 0);
        chk("rst_ovf", int'(ovf_flag), 0);
        rst = 1'b0;
        tick();

        // Step: 262144>>>3 = 32768 clamps to 32767.
`ifdef PCM_POSTPROC_DCBLOCK_EN
        exp2 = 32736;   // y = 262144 - 262144 + 262144 - 256 = 261888
`else
        exp2 = 32767;
`endif
        strobe(262144, 1'b1, 32767);
        strobe(262144, 1'b1, exp2);
        tick();
        tick();
        chk("step_level", int'(fifo_level), 2);
        chk("step_sat", int'(sat_flag), 1);
        drain();
        clear_flags();
        chk("step_sat_clr", int'(sat_flag), 0);

        // Negative bound: -262144>>>3 = -32768 fits exactly, no clamp.
        do_reset();
        pcm_in       = -24'sd262144;
        pcm_in_valid = 1'b1;
        exp_q.push_back(-32768);
        tick();                               // strobe edge N
        pcm_in_valid = 1'b0;
        chk("lat_n", int'(out_valid), 0);
        tick();                               // N+1
        chk("lat_n1", int'(out_valid), 0);
        tick();                               // N+2
        chk("lat_n2", int'(out_valid), 1);
        chk("neg_sat", int'(sat_flag), 0);
        drain();

        // Overflow: 9 samples into an 8-deep FIFO, the 9th (72) is dropped.
        do_reset();
        for (int k = 1; k <= 9; k++) strobe(8*k, (k <= 8), k);
        tick();
        tick();
        chk("ovf_level", int'(fifo_level), 8);
        chk("ovf_flag", int'(ovf_flag), 1);
        drain();
        chk("ovf_sticky", int'(ovf_flag), 1);
        clear_flags();
        chk("ovf_clr", int'(ovf_flag), 0);

        // Full FIFO with simultaneous push and pop.
        do_reset();
        for (int k = 1; k <= 8; k++) strobe(8*k, 1'b1, k);
        tick();
        tick();
        chk("full_level", int'(fifo_level), 8);
        strobe(80, 1'b1, 10);                 // edge N
        tick();                               // N+1, write happens at N+2
        out_ready = 1'b1;
        tick();                               // N+2: push and pop together
        out_ready = 1'b0;
        chk("pp_level", int'(fifo_level), 8);
        chk("pp_ovf", int'(ovf_flag), 0);
        drain();

        // Constant input streamed with the consumer always ready.
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) strobe(1000, 1'b1, 125);
        for (int k = 0; k < 4; k++) tick();
        chk("const_sat", int'(sat_flag), 0);
        drain();

        // Reset mid-stream: 3 samples queued, one in flight.
        do_reset();
        strobe(300000, 1'b1, 32767);
        strobe(40, 1'b1, 5);
        strobe(48, 1'b1, 6);
        tick();
        tick();
        chk("mid_level_pre", int'(fifo_level), 3);
        strobe(56, 1'b1, 7);
        rst = 1'b1;
        #1;
        exp_q.delete();
        chk("mid_valid", int'(out_valid), 0);
        chk("mid_level", int'(fifo_level), 0);
        chk("mid_sat", int'(sat_flag), 0);
        chk("mid_ovf", int'(ovf_flag), 0);
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        out_ready = 1'b0;
        chk("mid_after_valid", int'(out_valid), 0);
        chk("mid_after_level", int'(fifo_level), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
